// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: tick-driven obstacle scroll, spawn, retire and score engine for a side-scroller
module obstacle_scheduler #(
  parameter int TICK_DIV = 2000000,
  parameter int SPAWN_X = 1280,
  parameter int MIN_GAP = 300,
  parameter int PASS_PER_LEVEL = 12,
  parameter int MAX_SPEED = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        hit,
  output logic [43:0] obs_x,
  output logic [3:0]  obs_active,
  output logic [3:0]  speed,
  output logic        tick,
  output logic        game_over,
  output logic [15:0] score,
  output logic [1:0]  state
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);
  localparam logic [10:0] SX = 11'(SPAWN_X);
  localparam logic [10:0] GAP_MIN = 11'(MIN_GAP);
  localparam logic [4:0] LVL_STEP = 5'(PASS_PER_LEVEL);
  localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2, BAD = 2'd3} st_t;
  st_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [10:0] gap, gap_n, t_gap;
  logic [3:0] level, level_n, t_level;
  logic [7:0] lfsr, lfsr_n, t_lfsr;
  logic prev;
  logic [43:0] x_n, mv_x, t_x;
  logic [3:0] act_n, mv_act, t_act, speed_n, t_speed;
  logic [15:0] score_n, t_score;
  logic [2:0] n;
  logic [11:0] gap_sum;
  logic [16:0] score_sum;
  logic [4:0] lvl_sum;
  logic start_edge, spawn, lvl_up;
  assign start_edge = start_btn & ~prev;
  assign tick = st == RUN && cnt == CNT_TOP;
  assign game_over = st == OVER;
  assign state = st;
  // Scroll active slots and retire those that reach the left edge this tick
  always_comb begin
    n = '0;
    mv_x = obs_x;
    mv_act = obs_active;
    for (int i = 0; i < 4; i++) begin
      if (obs_active[i] && obs_x[11*i +: 11] <= {7'd0, speed}) begin
        mv_act[i] = 1'b0;
        mv_x[11*i +: 11] = SX;
        n = n + 3'd1;
      end else if (obs_active[i]) begin
        mv_x[11*i +: 11] = obs_x[11*i +: 11] - {7'd0, speed};
      end
    end
  end
  // Spawn into the pseudo-random slot once enough distance has scrolled; a spawn overrides a same-tick retirement
  assign spawn = gap >= GAP_MIN && !mv_act[lfsr[1:0]];
  assign t_act = mv_act | ({3'd0, spawn} << lfsr[1:0]);
  always_comb begin
    t_x = mv_x;
    if (spawn) t_x[11*lfsr[1:0] +: 11] = SX;
  end
  assign gap_sum = {1'b0, gap} + {8'd0, speed};
  assign t_gap = spawn ? 11'd0 : gap_sum[11] ? 11'h7FF : gap_sum[10:0];
  assign score_sum = {1'b0, score} + {14'd0, n};
  assign t_score = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign lvl_sum = {1'b0, level} + {2'd0, n};
  assign lvl_up = lvl_sum >= LVL_STEP;
  assign t_level = lvl_up ? 4'(lvl_sum - LVL_STEP) : lvl_sum[3:0];
  assign t_speed = lvl_up && speed < SPD_MAX ? speed + 4'd1 : speed;
  assign t_lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // Game FSM: start edge (re)initialises into RUN, hit ends the game, ticks commit the scroll results
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    x_n = obs_x;
    act_n = obs_active;
    speed_n = speed;
    score_n = score;
    gap_n = gap;
    level_n = level;
    lfsr_n = lfsr;
    if (st == BAD) begin
      st_n = IDLE;
    end else if (st != RUN && start_edge) begin
      st_n = RUN;
      cnt_n = '0;
      x_n = {4{SX}};
      act_n = '0;
      speed_n = 4'd1;
      score_n = '0;
      gap_n = '0;
      level_n = '0;
      lfsr_n = 8'hB5;
    end else if (st == RUN && hit) begin
      st_n = OVER;
    end else if (tick) begin
      cnt_n = '0;
      x_n = t_x;
      act_n = t_act;
      speed_n = t_speed;
      score_n = t_score;
      gap_n = t_gap;
      level_n = t_level;
      lfsr_n = t_lfsr;
    end else if (st == RUN) begin
      cnt_n = cnt + 1'b1;
    end
  end
  // State registers; prev starts high so a button held through reset does not start a game
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      obs_x <= {4{SX}};
      obs_active <= '0;
      speed <= 4'd1;
      score <= '0;
      gap <= '0;
      level <= '0;
      lfsr <= 8'hB5;
      prev <= 1'b1;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      obs_x <= x_n;
      obs_active <= act_n;
      speed <= speed_n;
      score <= score_n;
      gap <= gap_n;
      level <= level_n;
      lfsr <= lfsr_n;
      prev <= start_btn;
    end
  end
endmodule
